// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// data_mem_resp : 16-bit word memory with a 4-entry hit tracker; hits complete
//                 in the request cycle, misses after LATENCY cycles.
// Revision      : 1.0
// ============================================================================
module data_mem_resp #(
  parameter int LATENCY         = 4,
  parameter int ADDR_WORDS_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int         DEPTH    = 1 << ADDR_WORDS_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  valid_q;
  logic [12:0] tag_q [4];
  logic [15:0] mem_q [DEPTH];

  logic [1:0]                 idx;
  logic [12:0]                tag;
  logic [ADDR_WORDS_LOG2-1:0] widx;
  logic                       illegal, legal, match;
  logic                       done_c, stall_c, hit_c, err_c, mem_we_c, tag_we_c;
  logic [15:0]                dout_c;

  assign idx     = Addr[2:1];
  assign tag     = Addr[15:3];
  assign widx    = Addr[ADDR_WORDS_LOG2:1];
  assign illegal = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign legal   = (Rd ^ Wr) & ~Addr[0];
  assign match   = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_c   = 1'b0;
    stall_c  = 1'b0;
    hit_c    = 1'b0;
    err_c    = 1'b0;
    mem_we_c = 1'b0;
    tag_we_c = 1'b0;
    dout_c   = 16'h0000;
    case (state_q)
      ST_IDLE: begin
        if (illegal) begin
          err_c = 1'b1;
        end else if (legal) begin
          if (match) begin
            done_c   = 1'b1;
            hit_c    = 1'b1;
            mem_we_c = Wr;
            if (Rd) dout_c = mem_q[widx];
          end else begin
            stall_c = 1'b1;
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        if (cnt_q == 4'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DONE: begin
        // Inputs are re-sampled here; a dropped Wr means nothing is committed.
        done_c   = 1'b1;
        tag_we_c = 1'b1;
        mem_we_c = Wr & ~Rd & ~Addr[0];
        if (Rd && !Wr) dout_c = mem_q[widx];
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset must silence the outputs at once, even with a request on the inputs.
  assign Done     = done_c  & ~rst;
  assign Stall    = stall_c & ~rst;
  assign CacheHit = hit_c   & ~rst;
  assign err      = err_c   & ~rst;
  assign DataOut  = rst ? 16'h0000 : dout_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) tag_q[i] <= 13'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (tag_we_c) begin
        valid_q[idx] <= 1'b1;
        tag_q[idx]   <= tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem_q[widx] <= DataIn;
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// tb_data_mem_resp : cycle-by-cycle vector table for data_mem_resp, plus a
//                    latency sweep over LATENCY=2/4/15 instances.
// Revision         : 1.0
// ============================================================================
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = 16'h0000;
  logic [15:0] DataIn = 16'h0000;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;

  logic [15:0] dout4, dout2, dout15;
  logic        done4, stall4, hit4, err4;
  logic        done2, stall2, hit2, err2;
  logic        done15, stall15, hit15, err15;

  always #5 clk = ~clk;

  data_mem_resp dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(dout4), .Done(done4), .Stall(stall4), .CacheHit(hit4), .err(err4)
  );

  data_mem_resp #(.LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(dout2), .Done(done2), .Stall(stall2), .CacheHit(hit2), .err(err2)
  );

  data_mem_resp #(.LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(dout15), .Done(done15), .Stall(stall15), .CacheHit(hit15), .err(err15)
  );

  typedef struct {
    logic        rst, rd, wr;
    logic [15:0] addr, din;
    logic        done, stall, hit, err;
    logic [15:0] dout;
    logic        chk_dout;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic e_done, input logic e_stall, input logic e_hit,
                     input logic e_err, input logic [15:0] e_dout, input logic chk);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.din = d;
    v.done = e_done; v.stall = e_stall; v.hit = e_hit; v.err = e_err;
    v.dout = e_dout; v.chk_dout = chk;
    vecs.push_back(v);
  endtask

  // Miss with LATENCY=4: four stalled cycles, then the completion cycle.
  task automatic add_miss(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] e_dout,
                          input logic chk);
    for (int i = 0; i < 4; i++) add(0, rd, wr, a, d, 0, 1, 0, 0, 16'h0000, 1);
    add(0, rd, wr, a, d, 1, 0, 0, 0, e_dout, chk);
  endtask

  task automatic add_idle();
    add(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 1);
  endtask

  initial begin
    int first2, first4, first15;
    logic stall_ok;

    add(1, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 16'h0000, 1);
    add_idle();
    add_miss(0, 1, 16'h0010, 16'hBEEF, 16'h0000, 1);
    add(0, 1, 0, 16'h0010, 16'h0000, 1, 0, 1, 0, 16'hBEEF, 1);
    add_idle();
    add_miss(1, 0, 16'h0018, 16'h0000, 16'h0000, 0);
    add_miss(1, 0, 16'h0010, 16'h0000, 16'hBEEF, 1);
    add(0, 1, 0, 16'h0003, 16'h0000, 0, 0, 0, 1, 16'h0000, 1);
    add_miss(0, 1, 16'h0002, 16'h1111, 16'h0000, 1);
    add(0, 1, 1, 16'h0004, 16'h0000, 0, 0, 0, 1, 16'h0000, 1);
    add_miss(0, 1, 16'h0202, 16'hA5A5, 16'h0000, 1);
    add_miss(1, 0, 16'h0002, 16'h0000, 16'hA5A5, 1);
    add(0, 0, 1, 16'h0010, 16'h7777, 1, 0, 1, 0, 16'h0000, 1);
    add(0, 1, 0, 16'h0010, 16'h0000, 1, 0, 1, 0, 16'h7777, 1);
    add(0, 1, 0, 16'h0002, 16'h0000, 1, 0, 1, 0, 16'hA5A5, 1);
    add_miss(0, 1, 16'h0006, 16'h4444, 16'h0000, 1);
    // Write to an alias of word 3 with Wr dropped while busy: must not commit.
    add(0, 0, 1, 16'h0206, 16'h9999, 0, 1, 0, 0, 16'h0000, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 16'h0206, 16'h9999, 0, 1, 0, 0, 16'h0000, 1);
    add(0, 0, 0, 16'h0206, 16'h9999, 1, 0, 0, 0, 16'h0000, 1);
    add_miss(1, 0, 16'h0006, 16'h0000, 16'h4444, 1);
    add(0, 1, 0, 16'h0006, 16'h0000, 1, 0, 1, 0, 16'h4444, 1);
    add_idle();
    // Reset asserted in the second busy cycle of a write miss.
    add(0, 0, 1, 16'h0020, 16'h1234, 0, 1, 0, 0, 16'h0000, 1);
    add(0, 0, 1, 16'h0020, 16'h1234, 0, 1, 0, 0, 16'h0000, 1);
    add(1, 0, 1, 16'h0020, 16'h1234, 0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 1);
    add_idle();
    add_miss(0, 1, 16'h0020, 16'h5555, 16'h0000, 1);
    add(0, 1, 0, 16'h0020, 16'h0000, 1, 0, 1, 0, 16'h5555, 1);
    add_idle();

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; Rd = vecs[i].rd; Wr = vecs[i].wr;
      Addr = vecs[i].addr; DataIn = vecs[i].din;
      #2;
      n_vec++;
      if (done4 !== vecs[i].done || stall4 !== vecs[i].stall ||
          hit4 !== vecs[i].hit || err4 !== vecs[i].err ||
          (vecs[i].chk_dout && dout4 !== vecs[i].dout)) begin
        n_bad++;
        $display("FAIL vec%0d: Done/Stall/CacheHit/err/DataOut got %b/%b/%b/%b/%h, want %b/%b/%b/%b/%h",
                 i, done4, stall4, hit4, err4, dout4,
                 vecs[i].done, vecs[i].stall, vecs[i].hit, vecs[i].err, vecs[i].dout);
      end
    end

    // Latency sweep: one read miss seen by all three instances at once.
    @(negedge clk); rst = 1'b1; Rd = 1'b0; Wr = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); Rd = 1'b1; Addr = 16'h0040;
    first2 = -1; first4 = -1; first15 = -1; stall_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (first2  < 0 && done2)  first2  = c;
      if (first4  < 0 && done4)  first4  = c;
      if (first15 < 0 && done15) first15 = c;
      if (first15 < 0 && stall15 !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
    Rd = 1'b0;

    n_vec++;
    if (first2 != 2) begin
      n_bad++;
      $display("FAIL latency2: Done at cycle %0d, want 2", first2);
    end
    n_vec++;
    if (first4 != 4) begin
      n_bad++;
      $display("FAIL latency4: Done at cycle %0d, want 4", first4);
    end
    n_vec++;
    if (first15 != 15) begin
      n_bad++;
      $display("FAIL latency15: Done at cycle %0d, want 15", first15);
    end
    n_vec++;
    if (stall_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL latency15_stall: Stall low before Done, got %b want 1", stall_ok);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
